// File: rtl/tx_config_pkg.sv
// tx_config_pkg: instruction constants, field positions, tx FSM states and PE mask generation
package tx_config_pkg;
   localparam int PE_NUM = 32;
   localparam int INST_W = 64;
   localparam int ADDR_W = 32;
   localparam int LEN_W  = 12;
   localparam logic [3:0] WR_OP_O = 4'h2;
   localparam logic [3:0] WR_OP_P = 4'h3;
   localparam int OP_HI   = 61;
   localparam int OP_LO   = 58;
   localparam int BUF_HI  = 57;
   localparam int BUF_LO  = 52;
   localparam int SIZE_HI = 51;
   localparam int SIZE_LO = 40;
   localparam int ADDR_HI = 31;
   localparam int ADDR_LO = 0;
   typedef enum logic [1:0] {IDLE, CONF, XFER, DONE} tx_state_e;
   // bits shifted past PE_NUM fall off, so out-of-range buffer ids yield an empty mask
   function automatic logic [PE_NUM-1:0] gen_mask(input logic single, input logic [5:0] buf_id);
      return single ? PE_NUM'(1) << buf_id : PE_NUM'(15) << {buf_id, 2'b00};
   endfunction
endpackage

// File: rtl/tx_config_if.sv
// tx_config_if: instruction, buffer-readout config and DDR write-command handshakes
interface tx_config_if;
   import tx_config_pkg::*;
   logic              ins_valid;
   logic              ins_ready;
   logic [INST_W-1:0] ins;
   logic              obuf_conf_valid;
   logic              obuf_conf_ready;
   logic              pbuf_conf_valid;
   logic              pbuf_conf_ready;
   logic [3:0]        buf_conf_mode;
   logic [LEN_W-1:0]  buf_conf_trans_num;
   logic [PE_NUM-1:0] buf_conf_mask;
   logic              ddr_cmd_valid;
   logic              ddr_cmd_ready;
   logic [ADDR_W-1:0] ddr_cmd_addr;
   logic [LEN_W-1:0]  ddr_cmd_len;
   modport master (
      output ins_valid, ins, obuf_conf_ready, pbuf_conf_ready, ddr_cmd_ready,
      input  ins_ready, obuf_conf_valid, pbuf_conf_valid, buf_conf_mode, buf_conf_trans_num,
             buf_conf_mask, ddr_cmd_valid, ddr_cmd_addr, ddr_cmd_len
   );
   modport slave (
      input  ins_valid, ins, obuf_conf_ready, pbuf_conf_ready, ddr_cmd_ready,
      output ins_ready, obuf_conf_valid, pbuf_conf_valid, buf_conf_mode, buf_conf_trans_num,
             buf_conf_mask, ddr_cmd_valid, ddr_cmd_addr, ddr_cmd_len
   );
endinterface

// File: rtl/tx_beat_counter.sv
// tx_beat_counter: delivered-beat counter with clear, saturating at target
module tx_beat_counter
   import tx_config_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [LEN_W-1:0] target,
   output logic             done,
   output logic             reach
);
   logic [LEN_W-1:0] cnt;
   // reach also covers the cycle in which the final beat lands
   always_comb begin
      done = cnt == target;
      reach = done | (en & (cnt + LEN_W'(1) == target));
   end
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en && !done) cnt <= cnt + LEN_W'(1);
endmodule

// File: rtl/tx_config.sv
// tx_config: decodes write instructions, configures obuf/pbuf readout and issues one DDR write each.
// Optional TX_CONFIG_ERR_EN adds sticky err_flag/err_code reporting.
module tx_config
   import tx_config_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        layer_type,
   tx_config_if.slave        bus,
   input  logic              ddr_beat,
   output logic              ddr_data_sel,
   output logic              tx_done_pulse,
   output logic [PE_NUM-1:0] tx_buf_mask,
   output logic [1:0]        tx_buf_type
`ifdef TX_CONFIG_ERR_EN
   ,
   output logic              err_flag,
   output logic [1:0]        err_code
`endif
);
   tx_state_e state, next;
   logic [3:0] op;
   logic [LEN_W-1:0] size;
   logic accept, is_wr, latch, start, counting, hs_done, cnt_done, reach, unused;
   assign op = bus.ins[OP_HI:OP_LO];
   assign size = bus.ins[SIZE_HI:SIZE_LO];
   assign accept = bus.ins_valid & bus.ins_ready;
   assign is_wr = op == WR_OP_O || op == WR_OP_P;
   assign latch = accept & is_wr;
   assign start = latch & (size != '0);
   assign counting = state == CONF || state == XFER;
   assign hs_done = (~bus.obuf_conf_valid | bus.obuf_conf_ready)
                  & (~bus.pbuf_conf_valid | bus.pbuf_conf_ready)
                  & (~bus.ddr_cmd_valid | bus.ddr_cmd_ready);
   assign bus.buf_conf_trans_num = bus.ddr_cmd_len;
   assign tx_buf_mask = bus.buf_conf_mask;
   assign unused = ^{bus.ins[INST_W-1:OP_HI+1], bus.ins[SIZE_LO-1:ADDR_HI+1], cnt_done};
   tx_beat_counter u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (latch),
      .en     (ddr_beat & counting),
      .target (bus.ddr_cmd_len),
      .done   (cnt_done),
      .reach  (reach)
   );
   always_comb begin
      next = state == IDLE ? (latch ? (size == '0 ? DONE : CONF) : IDLE)
           : state == CONF ? (hs_done ? XFER : CONF)
           : state == XFER ? (reach ? DONE : XFER)
           : IDLE;
      tx_done_pulse = state == DONE;
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= next;
   always_ff @(posedge clk)
      if (rst) begin
         bus.ins_ready <= 1'b1;
         bus.obuf_conf_valid <= 1'b0;
         bus.pbuf_conf_valid <= 1'b0;
         bus.ddr_cmd_valid <= 1'b0;
         bus.buf_conf_mode <= '0;
         bus.buf_conf_mask <= '0;
         bus.ddr_cmd_addr <= '0;
         bus.ddr_cmd_len <= '0;
         ddr_data_sel <= 1'b0;
         tx_buf_type <= '0;
      end else begin
         bus.ins_ready <= next == IDLE;
         bus.obuf_conf_valid <= start ? op == WR_OP_O : bus.obuf_conf_valid & ~bus.obuf_conf_ready;
         bus.pbuf_conf_valid <= start ? op == WR_OP_P : bus.pbuf_conf_valid & ~bus.pbuf_conf_ready;
         bus.ddr_cmd_valid <= start | (bus.ddr_cmd_valid & ~bus.ddr_cmd_ready);
         if (latch) begin
            bus.buf_conf_mode <= layer_type;
            bus.buf_conf_mask <= gen_mask(layer_type[0], bus.ins[BUF_HI:BUF_LO]);
            bus.ddr_cmd_addr <= bus.ins[ADDR_HI:ADDR_LO];
            bus.ddr_cmd_len <= size;
            ddr_data_sel <= op == WR_OP_P;
            tx_buf_type <= op == WR_OP_P ? 2'b01 : 2'b10;
         end
      end
`ifdef TX_CONFIG_ERR_EN
   logic [1:0] err_now;
   always_comb
      err_now = ddr_beat && (state == IDLE || state == DONE) ? 2'b01
              : ddr_beat && counting && cnt_done ? 2'b10
              : accept && !is_wr ? 2'b11
              : 2'b00;
   always_ff @(posedge clk)
      if (rst) begin
         err_flag <= 1'b0;
         err_code <= '0;
      end else if (!err_flag && err_now != '0) begin
         err_flag <= 1'b1;
         err_code <= err_now;
      end
`endif
endmodule

// File: tb/tb_tx_config.sv
// tb_tx_config: directed stimulus against a timestamp-based transaction model of tx_config
module tb_tx_config;
   import tx_config_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] layer_type = '0;
   logic ddr_beat = 1'b0;
   logic ddr_data_sel, tx_done_pulse;
   logic [PE_NUM-1:0] tx_buf_mask;
   logic [1:0] tx_buf_type;
`ifdef TX_CONFIG_ERR_EN
   logic err_flag;
   logic [1:0] err_code;
   localparam int NP = 6;
`else
   localparam int NP = 5;
`endif
   tx_config_if bus();
   tx_config dut (
      .clk           (clk),
      .rst           (rst),
      .layer_type    (layer_type),
      .bus           (bus),
      .ddr_beat      (ddr_beat),
      .ddr_data_sel  (ddr_data_sel),
      .tx_done_pulse (tx_done_pulse),
      .tx_buf_mask   (tx_buf_mask),
      .tx_buf_type   (tx_buf_type)
`ifdef TX_CONFIG_ERR_EN
      ,
      .err_flag      (err_flag),
      .err_code      (err_code)
`endif
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   // hand-computed per-transfer expectations, in completion order
   logic [31:0] lit_mask [6] = '{32'h20, 32'hF00, 32'h2, 32'h8, 32'h80, 32'h1};
   logic [1:0]  lit_type [6] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
   int          lit_lat  [6] = '{6, 4, 8, 1, 4, 3};
   int n_chk = 0, n_err = 0, pulses = 0, timeouts = 0;
   logic end_req = 1'b0;
   int t_acc = -1, t_conf = -1, t_cmd = -1, t_last = -1, t_done = -1, beats = 0;
   logic m_p = 1'b0, rst_seen = 1'b0;
   logic [11:0] m_size = '0;
   logic [31:0] m_mask = '0, m_addr = '0;
   logic [3:0] m_mode = '0;
   function automatic logic [31:0] model_mask(input logic single, input logic [5:0] id);
      logic [31:0] m = '0;
      for (int i = 0; i < 32; i++) m[i] = single ? (i == int'(id)) : (i / 4 == int'(id));
      return m;
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask
   always @(negedge clk) begin
      logic act, cv, pv, dv;
      int h;
      if (cyc > 0) begin
         act = t_acc >= 0 && cyc > t_acc && (t_done < 0 || cyc <= t_done);
         cv = act && m_size != 0 && !m_p && (t_conf < 0 || cyc <= t_conf);
         pv = act && m_size != 0 && m_p && (t_conf < 0 || cyc <= t_conf);
         dv = act && m_size != 0 && (t_cmd < 0 || cyc <= t_cmd);
         chk("ins_ready", 64'(bus.ins_ready), 64'(!act));
         chk("obuf_conf_valid", 64'(bus.obuf_conf_valid), 64'(cv));
         chk("pbuf_conf_valid", 64'(bus.pbuf_conf_valid), 64'(pv));
         chk("ddr_cmd_valid", 64'(bus.ddr_cmd_valid), 64'(dv));
         chk("tx_done_pulse", 64'(tx_done_pulse), 64'(t_done == cyc));
         if (cv || pv) begin
            chk("buf_conf_mask", 64'(bus.buf_conf_mask), 64'(m_mask));
            chk("buf_conf_trans_num", 64'(bus.buf_conf_trans_num), 64'(m_size));
            chk("buf_conf_mode", 64'(bus.buf_conf_mode), 64'(m_mode));
         end
         if (dv) begin
            chk("ddr_cmd_addr", 64'(bus.ddr_cmd_addr), 64'(m_addr));
            chk("ddr_cmd_len", 64'(bus.ddr_cmd_len), 64'(m_size));
         end
         if (act && m_size != 0) chk("ddr_data_sel", 64'(ddr_data_sel), 64'(m_p));
         if (tx_done_pulse) begin
            if (pulses < NP) begin
               chk("done_mask", 64'(tx_buf_mask), 64'(lit_mask[pulses]));
               chk("done_type", 64'(tx_buf_type), 64'(lit_type[pulses]));
               chk("done_latency", 64'(cyc - t_acc), 64'(lit_lat[pulses]));
               chk("model_mask", 64'(m_mask), 64'(lit_mask[pulses]));
            end else chk("extra_pulse", 64'(pulses), 64'(NP - 1));
            pulses++;
         end
         if (rst_seen) begin
            chk("rst_ready", 64'(bus.ins_ready), 64'(1));
            chk("rst_sel", 64'(ddr_data_sel), 64'(0));
            chk("rst_mask", 64'(bus.buf_conf_mask), 64'(0));
            chk("rst_addr", 64'(bus.ddr_cmd_addr), 64'(0));
            chk("rst_len", 64'(bus.ddr_cmd_len), 64'(0));
            chk("rst_trans", 64'(bus.buf_conf_trans_num), 64'(0));
            chk("rst_mode", 64'(bus.buf_conf_mode), 64'(0));
            chk("rst_type", 64'(tx_buf_type), 64'(0));
            chk("rst_buf_mask", 64'(tx_buf_mask), 64'(0));
`ifdef TX_CONFIG_ERR_EN
            chk("rst_err_flag", 64'(err_flag), 64'(0));
            chk("rst_err_code", 64'(err_code), 64'(0));
`endif
         end
         if (end_req) begin
            chk("pulse_count", 64'(pulses), 64'(NP));
            chk("timeouts", 64'(timeouts), 64'(0));
`ifdef TX_CONFIG_ERR_EN
            chk("err_flag", 64'(err_flag), 64'(1));
            chk("err_code", 64'(err_code), 64'(2'b01));
`endif
            $display("Result: errors=%0d of %0d checks", n_err, n_chk);
            $finish;
         end
         // fold this cycle's inputs into the transaction timestamps
         if (rst) begin
            t_acc = -1;
            t_done = -1;
            rst_seen = 1'b1;
         end else begin
            rst_seen = 1'b0;
            if (!act && bus.ins_valid) begin
               if (bus.ins[61:58] == WR_OP_O || bus.ins[61:58] == WR_OP_P) begin
                  t_acc = cyc;
                  m_p = bus.ins[61:58] == WR_OP_P;
                  m_size = bus.ins[51:40];
                  m_addr = bus.ins[31:0];
                  m_mode = layer_type;
                  m_mask = model_mask(layer_type[0], bus.ins[57:52]);
                  t_conf = -1;
                  t_cmd = -1;
                  t_last = -1;
                  beats = 0;
                  t_done = m_size == 0 ? cyc + 1 : -1;
               end
            end else if (act && m_size != 0 && t_done < 0) begin
               if ((cv && bus.obuf_conf_ready) || (pv && bus.pbuf_conf_ready)) t_conf = cyc;
               if (dv && bus.ddr_cmd_ready) t_cmd = cyc;
               if (ddr_beat && beats < int'(m_size)) begin
                  beats++;
                  if (beats == int'(m_size)) t_last = cyc;
               end
               if (t_conf >= 0 && t_cmd >= 0 && t_last >= 0) begin
                  h = (t_conf > t_cmd ? t_conf : t_cmd) + 1;
                  t_done = (h > t_last ? h : t_last) + 1;
               end
            end
         end
      end
   end
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic issue(input logic [3:0] op, input logic [5:0] id, input logic [11:0] sz, input logic [31:0] a);
      int n = 0;
      bus.ins = {2'b00, op, id, sz, 8'h00, a};
      bus.ins_valid = 1'b1;
      while (!bus.ins_ready && n < 50) begin
         step(1);
         n++;
      end
      if (n >= 50) timeouts++;
      step(1);
      bus.ins_valid = 1'b0;
   endtask
   task automatic wait_pulses(input int k);
      int n = 0;
      while (pulses < k && n < 100) begin
         step(1);
         n++;
      end
      if (pulses < k) timeouts++;
   endtask
   initial begin
      bus.ins_valid = 1'b0;
      bus.ins = '0;
      bus.obuf_conf_ready = 1'b1;
      bus.pbuf_conf_ready = 1'b1;
      bus.ddr_cmd_ready = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      layer_type = 4'b0001;
      issue(WR_OP_O, 6'd5, 12'd4, 32'h1000);
      step(1);
      ddr_beat = 1'b1;
      step(4);
      ddr_beat = 1'b0;
      wait_pulses(1);
      step(2);
      layer_type = 4'b0000;
      issue(WR_OP_P, 6'd2, 12'd3, 32'h2000);
      ddr_beat = 1'b1;
      step(3);
      ddr_beat = 1'b0;
      wait_pulses(2);
      step(2);
      // command accept held off while data and obuf config complete early
      layer_type = 4'b0001;
      bus.ddr_cmd_ready = 1'b0;
      issue(WR_OP_O, 6'd1, 12'd2, 32'h3000);
      ddr_beat = 1'b1;
      step(2);
      ddr_beat = 1'b0;
      step(3);
      bus.ddr_cmd_ready = 1'b1;
      wait_pulses(3);
      step(2);
      issue(WR_OP_O, 6'd3, 12'd0, 32'h4000);
      wait_pulses(4);
      step(1);
      issue(4'hF, 6'd0, 12'd1, 32'h0);
      step(3);
      issue(WR_OP_O, 6'd0, 12'd8, 32'h5000);
      step(1);
      ddr_beat = 1'b1;
      step(2);
      ddr_beat = 1'b0;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(3);
      issue(WR_OP_P, 6'd7, 12'd2, 32'h6000);
      step(1);
      ddr_beat = 1'b1;
      step(2);
      ddr_beat = 1'b0;
      wait_pulses(5);
      step(2);
`ifdef TX_CONFIG_ERR_EN
      ddr_beat = 1'b1;
      step(1);
      ddr_beat = 1'b0;
      step(1);
      issue(WR_OP_O, 6'd0, 12'd1, 32'h7000);
      ddr_beat = 1'b1;
      step(3);
      ddr_beat = 1'b0;
      wait_pulses(6);
      step(2);
`endif
      end_req = 1'b1;
      step(3);
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end
endmodule
